cpu_core: RTL and testbench

- Small multi-cycle 32-bit CPU core with 8 general registers and a fixed 32-bit instruction format.
- Separate instruction and data memory ports (Harvard), both byte-addressed and little-endian.
- Reports HALT and ERROR status to the system through error_indicator.
- Sits between the instruction/data memories and the top-level system/test harness.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/cpu_alu.sv | 25 ++
 rtl/cpu_core.sv | 149 ++++++++++++++
 tb/tb_cpu_core.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcodes, instruction field positions, FSM states and status codes for cpu_core.
package cpu_pkg;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 23;
  localparam int RS1_MSB = 22;
  localparam int RS1_LSB = 20;
  localparam int RS2_MSB = 19;
  localparam int RS2_LSB = 17;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_XOR   = 6'h04;
  localparam logic [5:0] OP_SHL   = 6'h05;
  localparam logic [5:0] OP_SHR   = 6'h06;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_MOVI  = 6'h09;
  localparam logic [5:0] OP_MOVHI = 6'h0A;
  localparam logic [5:0] OP_LD    = 6'h10;
  localparam logic [5:0] OP_ST    = 6'h11;
  localparam logic [5:0] OP_B     = 6'h18;
  localparam logic [5:0] OP_BZ    = 6'h19;
  localparam logic [5:0] OP_BNZ   = 6'h1A;
  localparam logic [5:0] OP_NOP   = 6'h32;
  localparam logic [5:0] OP_HALT  = 6'h33;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC   = 3'd1,
    MEM    = 3'd2,
    HALTED = 3'd3,
    ERROR  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_RUN   = 2'b00;
  localparam logic [1:0] ERR_HALT  = 2'b01;
  localparam logic [1:0] ERR_FAULT = 2'b10;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Purpose: 32-bit ALU for register ops, ADDI and load/store address generation.
// Latency: purely combinational. Backpressure: none, result follows inputs.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = a + b;
    case (op)
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << b[4:0];
      OP_SHR:  result = a >> b[4:0];
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// Purpose: multi-cycle 32-bit Harvard CPU, FETCH->EXEC(->MEM); CPU_ALIGN_CHECK_EN traps unaligned LD/ST.
// Latency: 2 cycles per instruction, 3 for LD/ST. Backpressure: clk_en=0 freezes all state and outputs.
module cpu_core
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  output logic [31:0] instruction_memory_a,
  output logic        instruction_memory_en,
  input  logic [31:0] instruction_memory_v,
  output logic [31:0] data_memory_a,
  output logic        data_memory_read,
  output logic        data_memory_write,
  input  logic [31:0] data_memory_in_v,
  output logic [31:0] data_memory_out_v,
  output logic [1:0]  error_indicator
);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] ir;
  logic [31:0] regs [NUM_REGS];

  logic [5:0]  op;
  logic [2:0]  rd, rs1, rs2;
  logic [15:0] imm;
  logic [31:0] sext, rs1_val, rs2_val, rd_val, alu_b, alu_res, br_tgt;
  logic        wr_en;
  logic [31:0] wr_val;
  logic        unused_ir_bit;

  assign op            = ir[OP_MSB:OP_LSB];
  assign rd            = ir[RD_MSB:RD_LSB];
  assign rs1           = ir[RS1_MSB:RS1_LSB];
  assign rs2           = ir[RS2_MSB:RS2_LSB];
  assign imm           = ir[IMM_MSB:IMM_LSB];
  assign unused_ir_bit = ir[16];
  assign sext          = sext16(imm);
  assign rs1_val       = regs[rs1];
  assign rs2_val       = regs[rs2];
  assign rd_val        = regs[rd];
  assign br_tgt        = pc + 32'd4 + {sext[29:0], 2'b00};

  // The ALU also produces the LD/ST effective address; ir is stable through MEM.
  assign alu_b = (op == OP_ADDI || op == OP_LD || op == OP_ST) ? sext : rs2_val;

  cpu_alu u_alu (
    .op     (op),
    .a      (rs1_val),
    .b      (alu_b),
    .result (alu_res)
  );

  always_comb begin
    state_nxt             = state;
    pc_nxt                = pc;
    wr_en                 = 1'b0;
    wr_val                = '0;
    instruction_memory_en = 1'b0;
    instruction_memory_a  = '0;
    data_memory_a         = '0;
    data_memory_read      = 1'b0;
    data_memory_write     = 1'b0;
    data_memory_out_v     = '0;
    error_indicator       = ERR_RUN;
    case (state)
      FETCH: begin
        instruction_memory_en = 1'b1;
        instruction_memory_a  = pc;
        state_nxt             = EXEC;
      end
      EXEC: begin
        pc_nxt    = pc + 32'd4;
        state_nxt = FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ADDI: begin
            wr_en  = 1'b1;
            wr_val = alu_res;
          end
          OP_MOVI: begin
            wr_en  = 1'b1;
            wr_val = {16'h0000, imm};
          end
          OP_MOVHI: begin
            wr_en  = 1'b1;
            wr_val = {imm, rd_val[15:0]};
          end
          OP_LD, OP_ST: begin
`ifdef CPU_ALIGN_CHECK_EN
            state_nxt = (alu_res[1:0] != 2'b00) ? ERROR : MEM;
`else
            state_nxt = MEM;
`endif
          end
          OP_B:    pc_nxt = br_tgt;
          OP_BZ:   if (rs1_val == 32'd0) pc_nxt = br_tgt;
          OP_BNZ:  if (rs1_val != 32'd0) pc_nxt = br_tgt;
          OP_NOP:  ;
          OP_HALT: state_nxt = HALTED;
          default: state_nxt = ERROR;
        endcase
      end
      MEM: begin
        data_memory_a = alu_res;
        state_nxt     = FETCH;
        if (op == OP_LD) begin
          data_memory_read = 1'b1;
          wr_en            = 1'b1;
          wr_val           = data_memory_in_v;
        end else begin
          data_memory_write = 1'b1;
          data_memory_out_v = rd_val;
        end
      end
      HALTED:  error_indicator = ERR_HALT;
      ERROR:   error_indicator = ERR_FAULT;
      default: state_nxt = FETCH;
    endcase
    // Keep the memory side quiet while reset is held, even though state already reads FETCH.
    if (reset) begin
      instruction_memory_en = 1'b0;
      instruction_memory_a  = '0;
      data_memory_a         = '0;
      data_memory_read      = 1'b0;
      data_memory_write     = 1'b0;
      data_memory_out_v     = '0;
      error_indicator       = ERR_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (clk_en) begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == FETCH) ir <= instruction_memory_v;
      if (wr_en) regs[rd] <= wr_val;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: table of single-op programs plus hand-written multi-cycle sequences.
module tb_cpu_core;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic [31:0] instruction_memory_a, instruction_memory_v;
  logic        instruction_memory_en;
  logic [31:0] data_memory_a, data_memory_in_v, data_memory_out_v;
  logic        data_memory_read, data_memory_write;
  logic [1:0]  error_indicator;

  cpu_core dut (
    .clk                   (clk),
    .reset                 (reset),
    .clk_en                (clk_en),
    .instruction_memory_a  (instruction_memory_a),
    .instruction_memory_en (instruction_memory_en),
    .instruction_memory_v  (instruction_memory_v),
    .data_memory_a         (data_memory_a),
    .data_memory_read      (data_memory_read),
    .data_memory_write     (data_memory_write),
    .data_memory_in_v      (data_memory_in_v),
    .data_memory_out_v     (data_memory_out_v),
    .error_indicator       (error_indicator)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP_W = 32'hC800_0000;
  localparam logic [31:0] HLT_W = 32'hCC00_0000;

  logic [31:0] imem [64];
  logic [7:0]  dmem [1024];
  logic [9:0]  da;

  always_comb instruction_memory_v = imem[instruction_memory_a[7:2]];
  always_comb begin
    da = data_memory_a[9:0];
    data_memory_in_v = {dmem[da + 10'd3], dmem[da + 10'd2], dmem[da + 10'd1], dmem[da]};
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc_cnt, rd_cnt, wr_cnt, ovl_cnt, post_req, rd_cyc;
  logic frz_ok;
  logic [31:0] rd_addr, last_fetch;
  int fetch_cnt [64];

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input int rd, input int rs1,
                                      input int rs2, input logic [15:0] imm);
    logic [2:0] d, s1, s2;
    d = rd[2:0]; s1 = rs1[2:0]; s2 = rs2[2:0];
    return {op, d, s1, s2, 1'b0, imm};
  endfunction

  function automatic logic [31:0] word_at(input int addr);
    return {dmem[addr + 3], dmem[addr + 2], dmem[addr + 1], dmem[addr]};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = NOP_W;
    for (int i = 0; i < 1024; i++) dmem[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs until error_indicator leaves 00, committing stores and logging every request.
  task automatic run(input int freeze_at, input int max_cyc);
    cyc_cnt = 0; rd_cnt = 0; wr_cnt = 0; ovl_cnt = 0; post_req = 0;
    rd_cyc = -1; rd_addr = '0; last_fetch = '0; frz_ok = 1'b1;
    for (int i = 0; i < 64; i++) fetch_cnt[i] = 0;
    #1;
    while (error_indicator == ERR_RUN && cyc_cnt < max_cyc) begin
      if (instruction_memory_en) begin
        fetch_cnt[instruction_memory_a[7:2]]++;
        last_fetch = instruction_memory_a;
      end
      if (data_memory_read) begin
        rd_cnt++; rd_cyc = cyc_cnt; rd_addr = data_memory_a;
      end
      if (data_memory_write) wr_cnt++;
      if (int'(instruction_memory_en) + int'(data_memory_read) + int'(data_memory_write) > 1)
        ovl_cnt++;
      if (cyc_cnt == freeze_at) begin
        clk_en = 1'b0;
        repeat (4) begin
          @(negedge clk); #1;
          if (!(data_memory_read && data_memory_a == 32'h200 && !instruction_memory_en))
            frz_ok = 1'b0;
        end
        clk_en = 1'b1;
      end
      if (data_memory_write) begin
        for (int k = 0; k < 4; k++)
          dmem[(int'(data_memory_a[9:0]) + k) % 1024] = data_memory_out_v[8*k +: 8];
      end
      @(negedge clk); #1;
      cyc_cnt++;
    end
    chk("run_terminates", 32'(cyc_cnt < max_cyc), 32'd1);
    repeat (6) begin
      @(negedge clk);
      if (instruction_memory_en || data_memory_read || data_memory_write) post_req++;
    end
  endtask

  initial begin
    vecs[0]  = '{OP_ADD,  32'd5,          32'd7,          16'h0000, 32'h0000_000C};
    vecs[1]  = '{OP_ADD,  32'hFFFF_FFFF,  32'd2,          16'h0000, 32'h0000_0001};
    vecs[2]  = '{OP_SUB,  32'd3,          32'd5,          16'h0000, 32'hFFFF_FFFE};
    vecs[3]  = '{OP_AND,  32'hF0F0_1234,  32'h0FF0_FF00,  16'h0000, 32'h00F0_1200};
    vecs[4]  = '{OP_OR,   32'hF0F0_0000,  32'h0F0F_00FF,  16'h0000, 32'hFFFF_00FF};
    vecs[5]  = '{OP_XOR,  32'hFFFF_0000,  32'h0F0F_0F0F,  16'h0000, 32'hF0F0_0F0F};
    vecs[6]  = '{OP_SHL,  32'd1,          32'd31,         16'h0000, 32'h8000_0000};
    vecs[7]  = '{OP_SHL,  32'd1,          32'd33,         16'h0000, 32'h0000_0002};
    vecs[8]  = '{OP_SHR,  32'h8000_0000,  32'd31,         16'h0000, 32'h0000_0001};
    vecs[9]  = '{OP_SHR,  32'hDEAD_BEEF,  32'd4,          16'h0000, 32'h0DEA_DBEE};
    vecs[10] = '{OP_ADDI, 32'd10,         32'd0,          16'hFFFF, 32'h0000_0009};
    vecs[11] = '{OP_ADDI, 32'hFFFF_FFFF,  32'd0,          16'h0001, 32'h0000_0000};
    vecs[12] = '{OP_MOVI, 32'h1234_5678,  32'd0,          16'h8001, 32'h0000_8001};

    // Reset with NOP-filled memory, then fetch cadence.
    clear_mem();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_en", {31'd0, instruction_memory_en}, 32'd0);
    chk("reset_err", {30'd0, error_indicator}, 32'd0);
    chk("reset_ia", instruction_memory_a, 32'd0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("nop_en_c%0d", i), {31'd0, instruction_memory_en}, 32'((i % 2) == 0));
      if ((i % 2) == 0) chk($sformatf("nop_pc_c%0d", i), instruction_memory_a, 32'(2 * i));
      chk($sformatf("nop_err_c%0d", i), {30'd0, error_indicator}, 32'd0);
      @(negedge clk); #1;
    end

    // Table-driven: load operands into r1/r2, run one op into r3, store r3 to 0x100.
    for (int v = 0; v < 13; v++) begin
      clear_mem();
      imem[0] = enc(OP_MOVI,  1, 0, 0, vecs[v].a[15:0]);
      imem[1] = enc(OP_MOVHI, 1, 0, 0, vecs[v].a[31:16]);
      imem[2] = enc(OP_MOVI,  2, 0, 0, vecs[v].b[15:0]);
      imem[3] = enc(OP_MOVHI, 2, 0, 0, vecs[v].b[31:16]);
      if (vecs[v].op == OP_ADDI || vecs[v].op == OP_MOVI)
        imem[4] = enc(vecs[v].op, 3, 1, 0, vecs[v].imm);
      else
        imem[4] = enc(vecs[v].op, 3, 1, 2, 16'h0000);
      imem[5] = enc(OP_ST, 3, 0, 0, 16'h0100);
      imem[6] = HLT_W;
      do_reset();
      run(-1, 200);
      chk($sformatf("vec%0d_result", v), word_at(32'h100), vecs[v].exp);
      chk($sformatf("vec%0d_halt", v), {30'd0, error_indicator}, {30'd0, ERR_HALT});
      if (v == 0) begin
        chk("add_byte0", {24'd0, dmem[32'h100]}, 32'h0000_000C);
        chk("add_cycles", 32'(cyc_cnt), 32'd15);
        chk("halt_no_req", 32'(post_req), 32'd0);
      end
    end

    // LD timing and data path, with MOVHI then MOVI clearing the upper half.
    clear_mem();
    imem[0] = enc(OP_MOVHI, 1, 0, 0, 16'hDEAD);
    imem[1] = enc(OP_MOVI,  1, 0, 0, 16'hBEEF);
    imem[2] = enc(OP_LD,    4, 0, 0, 16'h0200);
    imem[3] = enc(OP_ST,    4, 0, 0, 16'h0104);
    imem[4] = enc(OP_ST,    1, 0, 0, 16'h0108);
    imem[5] = HLT_W;
    dmem[32'h200] = 8'h78; dmem[32'h201] = 8'h56; dmem[32'h202] = 8'h34; dmem[32'h203] = 8'h12;
    do_reset();
    run(-1, 200);
    chk("ld_value", word_at(32'h104), 32'h1234_5678);
    chk("movi_clears_hi", word_at(32'h108), 32'h0000_BEEF);
    chk("ld_read_cycle", 32'(rd_cyc), 32'd6);
    chk("ld_read_addr", rd_addr, 32'h0000_0200);
    chk("ld_read_count", 32'(rd_cnt), 32'd1);
    chk("st_write_count", 32'(wr_cnt), 32'd2);
    chk("ld_total_cycles", 32'(cyc_cnt), 32'd15);
    chk("req_overlap", 32'(ovl_cnt), 32'd0);

    // Countdown loop via BNZ back to the ADDI.
    clear_mem();
    imem[0] = enc(OP_MOVI, 1, 0, 0, 16'd3);
    imem[1] = enc(OP_ADDI, 1, 1, 0, 16'hFFFF);
    imem[2] = enc(OP_BNZ,  0, 1, 0, 16'hFFFE);
    imem[3] = HLT_W;
    do_reset();
    run(-1, 200);
    chk("loop_addi_iters", 32'(fetch_cnt[1]), 32'd3);
    chk("loop_bnz_iters", 32'(fetch_cnt[2]), 32'd3);
    chk("loop_halt_pc", last_fetch, 32'h0000_000C);
    chk("loop_cycles", 32'(cyc_cnt), 32'd16);
    chk("loop_halt", {30'd0, error_indicator}, {30'd0, ERR_HALT});

    // Illegal opcode is terminal and silent.
    clear_mem();
    imem[0] = 32'hFC00_0000;
    do_reset();
    run(-1, 200);
    chk("illegal_err", {30'd0, error_indicator}, {30'd0, ERR_FAULT});
    chk("illegal_cycles", 32'(cyc_cnt), 32'd2);
    chk("illegal_fetches", 32'(fetch_cnt[0] + fetch_cnt[1]), 32'd1);
    chk("illegal_no_req", 32'(post_req), 32'd0);

    // clk_en held low for 4 cycles while the LD sits in MEM.
    clear_mem();
    imem[0] = enc(OP_LD, 4, 0, 0, 16'h0200);
    imem[1] = enc(OP_ST, 4, 0, 0, 16'h010C);
    imem[2] = HLT_W;
    dmem[32'h200] = 8'h78; dmem[32'h201] = 8'h56; dmem[32'h202] = 8'h34; dmem[32'h203] = 8'h12;
    do_reset();
    run(2, 200);
    chk("freeze_outputs_held", {31'd0, frz_ok}, 32'd1);
    chk("freeze_ld_value", word_at(32'h10C), 32'h1234_5678);
    chk("freeze_cycles", 32'(cyc_cnt), 32'd8);

    // Reset during EXEC of MOVI must not write r1.
    clear_mem();
    imem[0] = enc(OP_MOVI, 1, 0, 0, 16'h0055);
    imem[1] = enc(OP_ST,   1, 0, 0, 16'h0100);
    imem[2] = HLT_W;
    dmem[32'h100] = 8'hFF; dmem[32'h101] = 8'hFF; dmem[32'h102] = 8'hFF; dmem[32'h103] = 8'hFF;
    do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("midreset_en", {31'd0, instruction_memory_en}, 32'd0);
    chk("midreset_wr", {31'd0, data_memory_write}, 32'd0);
    imem[0] = NOP_W;
    reset = 1'b0;
    run(-1, 200);
    chk("midreset_no_write", word_at(32'h100), 32'h0000_0000);
    chk("midreset_cycles", 32'(cyc_cnt), 32'd7);

    // Unaligned LD from 0x201.
    clear_mem();
    imem[0] = enc(OP_LD, 4, 0, 0, 16'h0201);
    imem[1] = enc(OP_ST, 4, 0, 0, 16'h0110);
    imem[2] = HLT_W;
    dmem[32'h200] = 8'h78; dmem[32'h201] = 8'h56; dmem[32'h202] = 8'h34; dmem[32'h203] = 8'h12;
    dmem[32'h204] = 8'hAB;
    do_reset();
    run(-1, 200);
`ifdef CPU_ALIGN_CHECK_EN
    chk("unaligned_err", {30'd0, error_indicator}, {30'd0, ERR_FAULT});
    chk("unaligned_no_read", 32'(rd_cnt), 32'd0);
    chk("unaligned_cycles", 32'(cyc_cnt), 32'd2);
`else
    chk("unaligned_value", word_at(32'h110), 32'hAB12_3456);
    chk("unaligned_halt", {30'd0, error_indicator}, {30'd0, ERR_HALT});
    chk("unaligned_read_addr", rd_addr, 32'h0000_0201);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
